// File: rtl/irq_receiver.sv
// irq_receiver: synchronizes NUM_IRQ interrupt lines (any irq_gen mode),
// latches events into a pending register and presents the lowest-index
// unmasked pending source over a valid/ready handshake.

// Per-source lane: synchronizer, polarity normalization, edge/level
// capture and the pending bit itself.
module irq_receiver_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       irq_i,
    input  logic [1:0] mode_i,
    input  logic       cap_en_i,
    input  logic       clr_i,
    output logic       pending_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   act;
    logic                   act_d;
    logic                   set;

    // Modes 1 (STROBE_N) and 2 (FIXED_N) are active low; odd modes are strobes.
    assign act = sync_q[SYNC_STAGES-1] ^ (mode_i[0] ^ mode_i[1]);
    assign set = cap_en_i & (mode_i[0] ? (act & ~act_d) : act);

    // Synchronizer, previous-cycle act and pending bit; set beats clear/ack.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q    <= '0;
            act_d     <= 1'b0;
            pending_o <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_i};
            act_d     <= act;
            pending_o <= set | (pending_o & ~clr_i);
        end
    end
endmodule

module irq_receiver #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic [NUM_IRQ-1:0]   irq_i,
    input  logic [2*NUM_IRQ-1:0] irq_mode_i,
    input  logic [NUM_IRQ-1:0]   mask_i,
    input  logic [NUM_IRQ-1:0]   clear_i,
    output logic [NUM_IRQ-1:0]   pending_o,
    output logic                 irq_o,
    output logic                 irq_valid_o,
    output logic [ID_W-1:0]      irq_id_o,
    input  logic                 irq_ready_i
);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_ACK} state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d, pick;
    logic [CNT_W-1:0]     warm_q;
    logic                 cap_en;
    logic                 hs;
    logic [NUM_IRQ-1:0]   req;
    logic [NUM_IRQ-1:0]   ack_vec;

    assign cap_en      = (warm_q == '0);
    assign req         = pending_o & mask_i;
    assign hs          = (state_q == S_PRESENT) && irq_ready_i;
    assign irq_valid_o = (state_q == S_PRESENT);
    assign irq_id_o    = id_q;

    // Hold capture off until the synchronizers and act_d carry real samples,
    // so reset-zero contents never look like an event on active-low sources.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)          warm_q <= CNT_W'(SYNC_STAGES + 1);
        else if (warm_q != '0)  warm_q <= warm_q - 1'b1;
    end

    // Lowest-index request wins; acknowledge decodes back to a one-hot clear.
    always_comb begin
        pick    = '0;
        ack_vec = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (req[i]) pick = ID_W'(i);
        for (int i = 0; i < NUM_IRQ; i++)
            ack_vec[i] = hs && (id_q == ID_W'(i));
    end

    genvar n;
    generate
        for (n = 0; n < NUM_IRQ; n++) begin : g_lane
            irq_receiver_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
                .clk_i     (clk_i),
                .arst_n_i  (arst_n_i),
                .irq_i     (irq_i[n]),
                .mode_i    (irq_mode_i[2*n +: 2]),
                .cap_en_i  (cap_en),
                .clr_i     (clear_i[n] | ack_vec[n]),
                .pending_o (pending_o[n])
            );
        end
    endgenerate

    // Arbiter next-state: latch ID in IDLE, hold it through PRESENT, one ACK gap.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_PRESENT;
                    id_d    = pick;
                end
            end
            S_PRESENT: if (irq_ready_i) state_d = S_ACK;
            S_ACK:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Arbiter state, presented ID and registered aggregate interrupt.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            irq_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            irq_o   <= |req;
        end
    end
endmodule

// File: tb/tb_irq_receiver.sv
// Directed bench for irq_receiver (NUM_IRQ=8, SYNC_STAGES=2).
// Inputs change just after the falling edge; outputs are checked there too.
module tb_irq_receiver;
    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic [7:0]  irq_i;
    logic [15:0] irq_mode_i;
    logic [7:0]  mask_i;
    logic [7:0]  clear_i;
    logic [7:0]  pending_o;
    logic        irq_o;
    logic        irq_valid_o;
    logic [2:0]  irq_id_o;
    logic        irq_ready_i;

    int n_chk  = 0;
    int n_fail = 0;

    irq_receiver #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .irq_i       (irq_i),
        .irq_mode_i  (irq_mode_i),
        .mask_i      (mask_i),
        .clear_i     (clear_i),
        .pending_o   (pending_o),
        .irq_o       (irq_o),
        .irq_valid_o (irq_valid_o),
        .irq_id_o    (irq_id_o),
        .irq_ready_i (irq_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Reset with a given line/mode configuration and wait past warm-up.
    task automatic do_reset(input logic [15:0] m, input logic [7:0] lines, input logic [7:0] msk);
        irq_mode_i  = m;
        irq_i       = lines;
        mask_i      = msk;
        clear_i     = '0;
        irq_ready_i = 1'b0;
        arst_n_i    = 1'b0;
        cyc(2);
        arst_n_i    = 1'b1;
        cyc(6);
    endtask

    initial begin
        logic any_pend;
        logic any_vld;
        logic [2:0] exp_ids [3];
        exp_ids[0] = 3'd1; exp_ids[1] = 3'd3; exp_ids[2] = 3'd6;

        // ---- reset / warm-up: STROBE_N lines idle high must not fire ----
        irq_mode_i  = 16'h5555;
        irq_i       = 8'hFF;
        mask_i      = 8'hFF;
        clear_i     = '0;
        irq_ready_i = 1'b0;
        arst_n_i    = 1'b0;
        cyc(2);
        chk("rst_pending", 32'(pending_o), 32'h0);
        chk("rst_irq_o",   32'(irq_o), 32'h0);
        chk("rst_valid",   32'(irq_valid_o), 32'h0);
        chk("rst_id",      32'(irq_id_o), 32'h0);
        arst_n_i = 1'b1;
        any_pend = 1'b0;
        any_vld  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            any_pend |= |pending_o;
            any_vld  |= irq_valid_o;
        end
        chk("warm_pending", 32'(any_pend), 32'h0);
        chk("warm_valid",   32'(any_vld), 32'h0);

        // ---- strobe capture, source 5 STROBE_P, 4-cycle pulse ----
        do_reset(16'h0C00, 8'h00, 8'hFF);
        irq_i = 8'h20;                     // sampled first at E0
        cyc(2);
        chk("strb_pend_e1", 32'(pending_o), 32'h00);
        cyc(1);
        chk("strb_pend_e2", 32'(pending_o), 32'h20);
        chk("strb_vld_e2",  32'(irq_valid_o), 32'h0);
        cyc(1);
        irq_i = 8'h00;                     // 4 cycles high
        chk("strb_vld_e3",  32'(irq_valid_o), 32'h1);
        chk("strb_id_e3",   32'(irq_id_o), 32'h5);
        chk("strb_irq_e3",  32'(irq_o), 32'h1);
        cyc(6);
        chk("strb_pend_hold", 32'(pending_o), 32'h20);
        irq_ready_i = 1'b1;
        cyc(1);
        irq_ready_i = 1'b0;
        chk("strb_ack_vld",  32'(irq_valid_o), 32'h0);
        chk("strb_ack_pend", 32'(pending_o), 32'h00);
        cyc(1);
        chk("strb_irq_fall", 32'(irq_o), 32'h0);
        cyc(4);
        chk("strb_one_event", 32'(pending_o), 32'h00);
        chk("strb_no_vld",    32'(irq_valid_o), 32'h0);

        // ---- priority and back-to-back handshake, ready held high ----
        do_reset(16'hFFFF, 8'h00, 8'hFF);
        irq_ready_i = 1'b1;
        irq_i = 8'h4A;
        cyc(2);
        irq_i = 8'h00;
        cyc(1);
        chk("prio_pend", 32'(pending_o), 32'h4A);
        for (int k = 0; k < 9; k++) begin
            cyc(1);
            chk($sformatf("prio_vld_%0d", k), 32'(irq_valid_o), 32'((k % 3) == 0));
            if ((k % 3) == 0)
                chk($sformatf("prio_id_%0d", k), 32'(irq_id_o), 32'(exp_ids[k/3]));
        end
        chk("prio_pend_end", 32'(pending_o), 32'h00);
        irq_ready_i = 1'b0;

        // ---- level set-wins, source 0 FIXED_N ----
        do_reset(16'h0002, 8'h01, 8'hFF);
        irq_i = 8'h00;                     // active low asserted
        cyc(4);
        chk("lvl_vld", 32'(irq_valid_o), 32'h1);
        chk("lvl_id",  32'(irq_id_o), 32'h0);
        cyc(1);
        irq_ready_i = 1'b1;
        cyc(1);
        irq_ready_i = 1'b0;
        chk("lvl_ack_vld",  32'(irq_valid_o), 32'h0);
        chk("lvl_set_wins", 32'(pending_o), 32'h01);
        cyc(2);
        chk("lvl_repres_vld", 32'(irq_valid_o), 32'h1);
        chk("lvl_repres_id",  32'(irq_id_o), 32'h0);
        irq_i = 8'h01;                     // release
        cyc(4);
        chk("lvl_still_pend", 32'(pending_o), 32'h01);
        clear_i = 8'h01;
        cyc(1);
        clear_i = 8'h00;
        chk("lvl_cleared", 32'(pending_o), 32'h00);
        chk("lvl_hold_vld", 32'(irq_valid_o), 32'h1);
        irq_ready_i = 1'b1;
        cyc(1);
        irq_ready_i = 1'b0;
        cyc(2);
        chk("lvl_idle_vld", 32'(irq_valid_o), 32'h0);

        // ---- mask gating and ID stability ----
        do_reset(16'h0030, 8'h00, 8'hFB);
        irq_i = 8'h04;
        cyc(2);
        irq_i = 8'h00;
        cyc(4);
        chk("msk_pend",  32'(pending_o), 32'h04);
        chk("msk_irq_o", 32'(irq_o), 32'h0);
        chk("msk_vld",   32'(irq_valid_o), 32'h0);
        mask_i = 8'hFF;
        cyc(1);
        chk("msk_on_vld", 32'(irq_valid_o), 32'h1);
        chk("msk_on_id",  32'(irq_id_o), 32'h2);
        chk("msk_on_irq", 32'(irq_o), 32'h1);
        mask_i  = 8'hFB;
        clear_i = 8'h04;
        cyc(1);
        clear_i = 8'h00;
        chk("stab_pend",  32'(pending_o), 32'h00);
        chk("stab_irq_o", 32'(irq_o), 32'h0);
        cyc(2);
        chk("stab_vld", 32'(irq_valid_o), 32'h1);
        chk("stab_id",  32'(irq_id_o), 32'h2);
        irq_ready_i = 1'b1;
        cyc(1);
        irq_ready_i = 1'b0;
        chk("stab_ack_vld", 32'(irq_valid_o), 32'h0);

        // ---- async reset while PRESENT ----
        do_reset(16'hFFFF, 8'h00, 8'hFF);
        irq_i = 8'h10;
        cyc(2);
        irq_i = 8'h00;
        cyc(2);
        chk("ar_pre_vld",  32'(irq_valid_o), 32'h1);
        chk("ar_pre_pend", 32'(pending_o), 32'h10);
        #2 arst_n_i = 1'b0;
        #1;
        chk("ar_vld",  32'(irq_valid_o), 32'h0);
        chk("ar_pend", 32'(pending_o), 32'h00);
        chk("ar_irq",  32'(irq_o), 32'h0);
        cyc(2);
        arst_n_i = 1'b1;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
